rvfi_csr_shadow_check: RTL and testbench

Sequential, multi-channel CSR consistency checker for the RVFI formal/simulation harness. It keeps a per-bit shadow copy of one CSR across all retired instructions on NRET channels and flags any retirement whose reported CSR read value contradicts the value established by earlier writes or reads. In counter mode it instead checks monotonic progress of a free-running counter CSR. It sits beside the per-instruction CSR checks and is driven by the same RVFI channel bundle.

---
 rtl/rvfi_csr_shadow_check.sv | 157 +++++++++++++++
 tb/tb_rvfi_csr_shadow_check.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rvfi_csr_shadow_check.sv
// Multi-channel RVFI CSR shadow checker: storage exact-match (MODE 0) or counter monotonicity (MODE 1).
// Optional retirement-order gap tracking via RISCV_FORMAL_CSR_SHADOW_ORDER_EN.
module rvfi_csr_shadow_lane #(
  parameter int CSR_W = 64,
  parameter int MODE  = 0
) (
  input  logic             i_part,
  input  logic             i_gap,
  input  logic [CSR_W-1:0] i_rmask,
  input  logic [CSR_W-1:0] i_wmask,
  input  logic [CSR_W-1:0] i_rdata,
  input  logic [CSR_W-1:0] i_wdata,
  input  logic [CSR_W-1:0] i_known,
  input  logic [CSR_W-1:0] i_shadow,
  output logic [CSR_W-1:0] o_known,
  output logic [CSR_W-1:0] o_shadow,
  output logic             o_mis
);
  logic [CSR_W-1:0] w_kpre;
  logic [CSR_W-1:0] w_diff;

  assign w_diff = i_rdata - i_shadow;

  always_comb begin
    // an order gap invalidates knowledge even for skipped channels
    w_kpre   = i_gap ? '0 : i_known;
    o_known  = w_kpre;
    o_shadow = i_shadow;
    o_mis    = 1'b0;
    if (i_part) begin
      if (MODE == 0) begin
        o_mis    = |((i_rdata ^ i_shadow) & i_rmask & w_kpre);
        o_known  = w_kpre | i_rmask | i_wmask;
        o_shadow = (i_shadow & ~(i_rmask | i_wmask)) | (i_rdata & i_rmask & ~i_wmask)
                 | (i_wdata & i_wmask);
      end else begin
        if (&i_rmask) begin
          o_mis    = (&w_kpre) && w_diff[CSR_W-1];
          o_known  = '1;
          o_shadow = i_rdata;
        end else if (|i_rmask) begin
          o_known = '0;
        end
        o_known  = o_known | i_wmask;
        o_shadow = (o_shadow & ~i_wmask) | (i_wdata & i_wmask);
      end
    end
  end
endmodule

module rvfi_csr_shadow_check #(
  parameter int NRET  = 1,
  parameter int CSR_W = 64,
  parameter int MODE  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 check,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET-1:0]      rvfi_trap,
  input  logic [64*NRET-1:0]   rvfi_order,
  input  logic [64*NRET-1:0]   csr_rmask,
  input  logic [64*NRET-1:0]   csr_wmask,
  input  logic [64*NRET-1:0]   csr_rdata,
  input  logic [64*NRET-1:0]   csr_wdata,
  output logic [CSR_W-1:0]     shadow_known,
  output logic [CSR_W-1:0]     shadow_value,
  output logic                 err,
  output logic [1:0]           err_chan,
  output logic [63:0]          err_order
);
  logic [CSR_W-1:0] r_known, r_shadow;
  logic             r_err;
  logic [1:0]       r_err_chan;
  logic [63:0]      r_err_order;

  logic [NRET:0][CSR_W-1:0] w_known, w_shadow;
  logic [NRET-1:0]          w_mis, w_gap;
  logic [1:0]               w_first_chan;
  logic [63:0]              w_first_order;

  assign w_known[0]  = r_known;
  assign w_shadow[0] = r_shadow;

`ifdef RISCV_FORMAL_CSR_SHADOW_ORDER_EN
  logic [63:0]         r_exp_order;
  logic [NRET:0][63:0] w_exp;
  assign w_exp[0] = r_exp_order;
`endif

  genvar k;
  generate
    for (k = 0; k < NRET; k++) begin : g_lane
`ifdef RISCV_FORMAL_CSR_SHADOW_ORDER_EN
      assign w_gap[k]   = rvfi_valid[k] && (rvfi_order[k*64 +: 64] != w_exp[k]);
      assign w_exp[k+1] = rvfi_valid[k] ? rvfi_order[k*64 +: 64] + 64'd1 : w_exp[k];
`else
      assign w_gap[k] = 1'b0;
`endif
      rvfi_csr_shadow_lane #(.CSR_W(CSR_W), .MODE(MODE)) u_lane (
        .i_part   (rvfi_valid[k] && !rvfi_trap[k]),
        .i_gap    (w_gap[k]),
        .i_rmask  (csr_rmask[k*64 +: CSR_W]),
        .i_wmask  (csr_wmask[k*64 +: CSR_W]),
        .i_rdata  (csr_rdata[k*64 +: CSR_W]),
        .i_wdata  (csr_wdata[k*64 +: CSR_W]),
        .i_known  (w_known[k]),
        .i_shadow (w_shadow[k]),
        .o_known  (w_known[k+1]),
        .o_shadow (w_shadow[k+1]),
        .o_mis    (w_mis[k])
      );
    end
  endgenerate

  // lowest mismatching slot wins
  always_comb begin
    w_first_chan  = '0;
    w_first_order = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (w_mis[i]) begin
        w_first_chan  = 2'(i);
        w_first_order = rvfi_order[i*64 +: 64];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_known     <= '0;
      r_shadow    <= '0;
      r_err       <= 1'b0;
      r_err_chan  <= '0;
      r_err_order <= '0;
`ifdef RISCV_FORMAL_CSR_SHADOW_ORDER_EN
      r_exp_order <= '0;
`endif
    end else begin
      r_known  <= w_known[NRET];
      r_shadow <= w_shadow[NRET];
`ifdef RISCV_FORMAL_CSR_SHADOW_ORDER_EN
      r_exp_order <= w_exp[NRET];
`endif
      if (check && (|w_mis) && !r_err) begin
        r_err       <= 1'b1;
        r_err_chan  <= w_first_chan;
        r_err_order <= w_first_order;
      end
    end
  end

  assign shadow_known = r_known;
  assign shadow_value = r_shadow;
  assign err          = r_err;
  assign err_chan     = r_err_chan;
  assign err_order    = r_err_order;
endmodule

// File: tb/tb_rvfi_csr_shadow_check.sv
// Directed bench: NRET=2 storage-mode instance and NRET=1 counter-mode instance.
module tb_rvfi_csr_shadow_check;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic check = 1'b1;
  always #5 clock = ~clock;

  // storage instance, two channels
  logic [1:0]   v0, t0;
  logic [127:0] o0, rm0, wm0, rd0, wd0;
  logic [63:0]  known0, val0, eord0;
  logic         err0;
  logic [1:0]   ech0;
  // counter instance, one channel
  logic [0:0]   v1, t1;
  logic [63:0]  o1, rm1, wm1, rd1, wd1;
  logic [63:0]  known1, val1, eord1;
  logic         err1;
  logic [1:0]   ech1;

  int n_chk = 0, n_fail = 0;
  logic [63:0] c0 = 0, c1 = 0;

  rvfi_csr_shadow_check #(.NRET(2), .CSR_W(64), .MODE(0)) u_dut0 (
    .clock(clock), .reset(reset), .check(check),
    .rvfi_valid(v0), .rvfi_trap(t0), .rvfi_order(o0),
    .csr_rmask(rm0), .csr_wmask(wm0), .csr_rdata(rd0), .csr_wdata(wd0),
    .shadow_known(known0), .shadow_value(val0),
    .err(err0), .err_chan(ech0), .err_order(eord0));

  rvfi_csr_shadow_check #(.NRET(1), .CSR_W(64), .MODE(1)) u_dut1 (
    .clock(clock), .reset(reset), .check(check),
    .rvfi_valid(v1), .rvfi_trap(t1), .rvfi_order(o1),
    .csr_rmask(rm1), .csr_wmask(wm1), .csr_rdata(rd1), .csr_wdata(wd1),
    .shadow_known(known1), .shadow_value(val1),
    .err(err1), .err_chan(ech1), .err_order(eord1));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic idle();
    v0 = '0; t0 = '0; o0 = '0; rm0 = '0; wm0 = '0; rd0 = '0; wd0 = '0;
    v1 = '0; t1 = '0; o1 = '0; rm1 = '0; wm1 = '0; rd1 = '0; wd1 = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic ret0(input int s, input logic trap, input logic [63:0] rm, input logic [63:0] wm,
                      input logic [63:0] rd, input logic [63:0] wd);
    v0[s] = 1'b1; t0[s] = trap;
    o0[s*64 +: 64] = c0; c0++;
    rm0[s*64 +: 64] = rm; wm0[s*64 +: 64] = wm;
    rd0[s*64 +: 64] = rd; wd0[s*64 +: 64] = wd;
  endtask

  task automatic ret1(input logic [63:0] rd);
    v1 = 1'b1; t1 = 1'b0; o1 = c1; c1++;
    rm1 = ONES; rd1 = rd;
  endtask

  logic [63:0] cap;

  initial begin
    idle();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("rst_known0", known0, 64'h0);
    chk("rst_val0", val0, 64'h0);
    chk("rst_err0", {63'h0, err0}, 64'h0);
    chk("rst_chan0", {62'h0, ech0}, 64'h0);
    chk("rst_order0", eord0, 64'h0);
    chk("rst_known1", known1, 64'h0);

    // counter mode: wrap forward is fine, backward step is flagged
    ret1(64'hFFFF_FFFF_FFFF_FFFE); tick();
    chk("cnt_first_err", {63'h0, err1}, 64'h0);
    chk("cnt_first_known", known1, ONES);
    ret1(64'h3); tick();
    chk("cnt_wrap_err", {63'h0, err1}, 64'h0);
    chk("cnt_wrap_val", val1, 64'h3);
    ret1(64'h2); tick();
    chk("cnt_back_err", {63'h0, err1}, 64'h1);
    chk("cnt_back_order", eord1, 64'h2);

    // storage mode, slot 0 only
    ret0(0, 1'b0, 64'h0, ONES, 64'h0, 64'h1234); tick();
    chk("wr_val", val0, 64'h1234);
    chk("wr_known", known0, ONES);
    ret0(0, 1'b0, ONES, 64'h0, 64'h1234, 64'h0); tick();
    chk("rd_match_err", {63'h0, err0}, 64'h0);
    ret0(0, 1'b0, 64'h0, ONES, 64'h0, 64'h0); tick();
    ret0(0, 1'b1, 64'h0, ONES, 64'h0, 64'hFF); tick();
    chk("trap_val", val0, 64'h0);
    ret0(0, 1'b0, ONES, 64'h0, 64'h0, 64'h0); tick();
    chk("trap_rd_err", {63'h0, err0}, 64'h0);
    ret0(0, 1'b0, 64'h0, 64'hFF00, 64'h0, 64'hABCD); tick();
    chk("part_wr_val", val0, 64'hAB00);

    // check=0: mismatch ignored, shadow still follows the read
    check = 1'b0;
    ret0(0, 1'b0, ONES, 64'h0, 64'h1, 64'h0); tick();
    check = 1'b1;
    chk("nochk_err", {63'h0, err0}, 64'h0);
    chk("nochk_val", val0, 64'h1);

    // same-cycle write on slot 0 seen by read on slot 1
    ret0(0, 1'b0, 64'h0, ONES, 64'h0, 64'hAA);
    ret0(1, 1'b0, ONES, 64'h0, 64'hAA, 64'h0); tick();
    chk("fwd_match_err", {63'h0, err0}, 64'h0);
    ret0(0, 1'b0, 64'h0, ONES, 64'h0, 64'hAA);
    cap = c0;
    ret0(1, 1'b0, ONES, 64'h0, 64'hAB, 64'h0); tick();
    chk("fwd_mis_err", {63'h0, err0}, 64'h1);
    chk("fwd_mis_chan", {62'h0, ech0}, 64'h1);
    chk("fwd_mis_order", eord0, cap);
    // a later slot-0 error must not overwrite the capture
    ret0(0, 1'b0, ONES, 64'h0, 64'h5, 64'h0); tick();
    chk("sticky_chan", {62'h0, ech0}, 64'h1);
    chk("sticky_order", eord0, cap);

    // reset mid-stream drops knowledge and the error
    ret0(0, 1'b0, 64'h0, ONES, 64'h0, 64'h55); tick();
    reset = 1'b0; tick(); reset = 1'b1; c0 = 0;
    chk("mid_rst_err", {63'h0, err0}, 64'h0);
    chk("mid_rst_known", known0, 64'h0);
    ret0(0, 1'b0, ONES, 64'h0, 64'h99, 64'h0); tick();
    chk("post_rst_err", {63'h0, err0}, 64'h0);
    chk("post_rst_known", known0, ONES);
    chk("post_rst_val", val0, 64'h99);

    // order gap between a write and a contradicting read
    ret0(0, 1'b0, 64'h0, ONES, 64'h0, 64'h10); tick();
    c0++;
    cap = c0;
    ret0(0, 1'b0, ONES, 64'h0, 64'h20, 64'h0); tick();
`ifdef RISCV_FORMAL_CSR_SHADOW_ORDER_EN
    chk("gap_err", {63'h0, err0}, 64'h0);
    chk("gap_val", val0, 64'h20);
`else
    chk("gap_err", {63'h0, err0}, 64'h1);
    chk("gap_order", eord0, cap);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
